// File: rtl/uart_cmd_engine.sv
// Host command engine: byte-serial command parser driving SRAM, log BRAM and GDP.
// Single and bulk memory accesses, log access, PING, GDP start, argument timeout.
module uart_cmd_engine #(
  parameter int ADDR_W         = 16,
  parameter int DATA_BYTES     = 2,
  parameter int LOG_AW         = 10,
  parameter int LOG_BYTES      = 3,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_req,
  input  logic                    tx_busy,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  input  logic                    mem_busy,
  input  logic                    mem_rvalid,
  output logic [LOG_AW-1:0]       log_addr,
  output logic [8*LOG_BYTES-1:0]  log_wdata,
  input  logic [8*LOG_BYTES-1:0]  log_rdata,
  input  logic                    log_rvalid,
  output logic                    log_wr,
  output logic                    log_rd,
  output logic                    gdp_trigger_init
);

  localparam int AB  = (ADDR_W + 7) / 8;
  localparam int AW8 = 8 * AB;
  localparam int DW  = 8 * DATA_BYTES;
  localparam int LW  = 8 * LOG_BYTES;
  localparam int MB  = (DATA_BYTES > LOG_BYTES) ? DATA_BYTES : LOG_BYTES;
  localparam int MW  = 8 * MB;
  localparam int TW  = 8 * (MB + 1);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARGS = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_BRX  = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;
  localparam logic [2:0] S_GAP  = 3'd7;

  localparam logic [7:0] OP_BWR  = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_BRD  = 8'h04;
  localparam logic [7:0] OP_LWR  = 8'h10;
  localparam logic [7:0] OP_LRD  = 8'h11;
  localparam logic [7:0] OP_PING = 8'h80;
  localparam logic [7:0] OP_GDP  = 8'h81;

  logic [2:0]      r_state;
  logic [7:0]      r_op;
  logic [7:0]      r_idx;
  logic [AW8-1:0]  r_addr;
  logic [AW8-1:0]  r_cnt;
  logic [MW-1:0]   r_data;
  logic [TW-1:0]   r_txbuf;
  logic [7:0]      r_txn;
  logic            r_last;
  logic            r_pend;
  logic [CW-1:0]   r_tmo;
  logic [7:0]      r_tx_data;
  logic            r_tx_req;
  logic            r_mem_req;
  logic            r_mem_wr;
  logic            r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [LOG_AW-1:0] r_log_addr;
  logic [LW-1:0]   r_log_wdata;
  logic            r_log_wr;
  logic            r_log_rd;
  logic            r_gdp;

  logic [7:0]      w_nargs;
  logic            w_valid_op;
  logic            w_bulk;
  logic            w_tmo;
  logic [AW8-1:0]  w_addr_nx;
  logic [AW8-1:0]  w_cnt_nx;
  logic [MW-1:0]   w_data_nx;

  assign w_bulk    = (r_op == OP_BWR) || (r_op == OP_BRD);
  assign w_addr_nx = (r_addr << 8) | AW8'(rx_data);
  assign w_cnt_nx  = (r_cnt << 8) | AW8'(rx_data);
  assign w_data_nx = (r_data << 8) | MW'(rx_data);
  // r_tmo counts cycles since the last byte, that byte's cycle being 1
  assign w_tmo     = !rx_valid && (r_tmo == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nargs = 8'(AB);
    unique case (r_op)
      OP_BWR, OP_BRD: w_nargs = 8'(2 * AB);
      OP_WR:          w_nargs = 8'(AB + DATA_BYTES);
      OP_LWR:         w_nargs = 8'(AB + LOG_BYTES);
      default:        w_nargs = 8'(AB);
    endcase
  end

  always_comb begin
    w_valid_op = 1'b0;
    unique case (rx_data)
      OP_BWR, OP_WR, OP_RD, OP_BRD,
      OP_LWR, OP_LRD, OP_PING, OP_GDP: w_valid_op = 1'b1;
      default:                         w_valid_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_txbuf     <= '0;
      r_txn       <= '0;
      r_last      <= 1'b0;
      r_pend      <= 1'b0;
      r_tmo       <= '0;
      r_tx_data   <= '0;
      r_tx_req    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_log_addr  <= '0;
      r_log_wdata <= '0;
      r_log_wr    <= 1'b0;
      r_log_rd    <= 1'b0;
      r_gdp       <= 1'b0;
    end else begin
      r_tx_req <= 1'b0;
      r_mem_wr <= 1'b0;
      r_mem_rd <= 1'b0;
      r_log_wr <= 1'b0;
      r_log_rd <= 1'b0;
      r_gdp    <= 1'b0;
      if (rx_valid)
        r_tmo <= CW'(1);
      else if (r_state == S_ARGS || r_state == S_BRX)
        r_tmo <= r_tmo + CW'(1);
      else
        r_tmo <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_op   <= rx_data;
            r_idx  <= '0;
            r_data <= '0;
            r_txn  <= '0;
            r_last <= 1'b0;
            r_pend <= 1'b0;
            if (!w_valid_op)
              r_state <= S_ERR;
            else begin
              r_mem_req <= 1'b1;
              if (rx_data == OP_PING)
                r_state <= S_ACK;
              else if (rx_data == OP_GDP)
                r_state <= S_EXEC;
              else
                r_state <= S_ARGS;
            end
          end
        end
        S_ARGS: begin
          if (w_tmo)
            r_state <= S_ERR;
          else if (rx_valid) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx < 8'(AB))
              r_addr <= w_addr_nx;
            else if (w_bulk)
              r_cnt <= w_cnt_nx;
            else
              r_data <= w_data_nx;
            if (r_idx == w_nargs - 8'd1) begin
              r_idx <= '0;
              if (r_op == OP_BWR)
                r_state <= (w_cnt_nx == '0) ? S_ACK : S_BRX;
              else if (r_op == OP_BRD) begin
                r_txbuf <= {8'h02, MW'(0)};
                r_txn   <= 8'd1;
                r_state <= S_SEND;
              end else
                r_state <= S_EXEC;
            end
          end
        end
        S_BRX: begin
          if (w_tmo)
            r_state <= S_ERR;
          else if (rx_valid) begin
            r_data <= w_data_nx;
            r_idx  <= r_idx + 8'd1;
            if (r_idx == 8'(DATA_BYTES - 1)) begin
              r_idx   <= '0;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          unique case (r_op)
            OP_BWR, OP_WR: begin
              if (!mem_busy) begin
                r_mem_wr    <= 1'b1;
                r_mem_addr  <= r_addr[ADDR_W-1:0];
                r_mem_wdata <= r_data[DW-1:0];
                r_addr      <= r_addr + AW8'(1);
                r_cnt       <= r_cnt - AW8'(1);
                r_state     <= (r_op == OP_BWR && r_cnt != AW8'(1)) ? S_BRX : S_ACK;
              end
            end
            OP_RD, OP_BRD: begin
              if (!r_pend) begin
                if (!mem_busy) begin
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= r_addr[ADDR_W-1:0];
                  r_pend     <= 1'b1;
                end
              end else if (mem_rvalid) begin
                r_pend  <= 1'b0;
                r_addr  <= r_addr + AW8'(1);
                r_cnt   <= r_cnt - AW8'(1);
                r_state <= S_SEND;
                if (r_op == OP_RD) begin
                  r_txbuf <= TW'({8'h02, mem_rdata}) << (8 * (MB - DATA_BYTES));
                  r_txn   <= 8'(DATA_BYTES + 1);
                end else begin
                  r_txbuf <= TW'(mem_rdata) << (8 * (MB + 1 - DATA_BYTES));
                  r_txn   <= 8'(DATA_BYTES);
                end
              end
            end
            OP_LWR: begin
              r_log_wr    <= 1'b1;
              r_log_addr  <= r_addr[LOG_AW-1:0];
              r_log_wdata <= r_data[LW-1:0];
              r_state     <= S_ACK;
            end
            OP_LRD: begin
              if (!r_pend) begin
                r_log_rd   <= 1'b1;
                r_log_addr <= r_addr[LOG_AW-1:0];
                r_pend     <= 1'b1;
              end else if (log_rvalid) begin
                r_pend  <= 1'b0;
                r_txbuf <= TW'({8'h02, log_rdata}) << (8 * (MB - LOG_BYTES));
                r_txn   <= 8'(LOG_BYTES + 1);
                r_state <= S_SEND;
              end
            end
            OP_GDP: begin
              r_gdp   <= 1'b1;
              r_state <= S_ACK;
            end
            default: r_state <= S_ERR;
          endcase
        end
        S_SEND: begin
          if (!tx_busy) begin
            r_tx_req  <= 1'b1;
            r_tx_data <= r_txbuf[TW-1 -: 8];
            r_txbuf   <= r_txbuf << 8;
            r_txn     <= r_txn - 8'd1;
            r_state   <= S_GAP;
          end
        end
        S_ACK, S_ERR: begin
          if (!tx_busy) begin
            r_tx_req  <= 1'b1;
            r_tx_data <= (r_state == S_ACK) ? 8'h01 : 8'hFF;
            r_last    <= 1'b1;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_last) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_txn != 8'd0)
            r_state <= S_SEND;
          else if (r_op == OP_BRD && r_cnt != '0)
            r_state <= S_EXEC;
          else
            r_state <= S_ACK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data          = r_tx_data;
  assign tx_req           = r_tx_req;
  assign mem_req          = r_mem_req;
  assign mem_wr           = r_mem_wr;
  assign mem_rd           = r_mem_rd;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign log_addr         = r_log_addr;
  assign log_wdata        = r_log_wdata;
  assign log_wr           = r_log_wr;
  assign log_rd           = r_log_rd;
  assign gdp_trigger_init = r_gdp;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine with models of the UART tx,
// an SRAM controller (5-cycle busy) and a log BRAM (delayed read).
module tb_uart_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_busy;
  logic        mem_req, mem_wr, mem_rd;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_busy;
  logic        mem_rvalid = 1'b0;
  logic [9:0]  log_addr;
  logic [23:0] log_wdata;
  logic [23:0] log_rdata = '0;
  logic        log_rvalid = 1'b0;
  logic        log_wr, log_rd, gdp_trigger_init;

  int checks = 0;
  int errors = 0;

  uart_cmd_engine #(
    .ADDR_W(16), .DATA_BYTES(2), .LOG_AW(10),
    .LOG_BYTES(3), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .mem_rvalid(mem_rvalid),
    .log_addr(log_addr), .log_wdata(log_wdata), .log_rdata(log_rdata),
    .log_rvalid(log_rvalid), .log_wr(log_wr), .log_rd(log_rd),
    .gdp_trigger_init(gdp_trigger_init)
  );

  always #5 clk = ~clk;

  // transmitter model
  int         cyc = 0;
  int         last_rx_cyc = 0;
  logic [7:0] txq[$];
  int         txcyc[$];
  int         tx_cnt = 0;
  int         tx_viol = 0;
  logic       prev_tx_req = 1'b0;
  assign tx_busy = (tx_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_tx_req <= tx_req;
    if (rx_valid) last_rx_cyc <= cyc;
    if (tx_req) begin
      txq.push_back(tx_data);
      txcyc.push_back(cyc);
      if (tx_busy || prev_tx_req) tx_viol <= tx_viol + 1;
      tx_cnt <= 4;
    end else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  // SRAM controller model
  logic [15:0] sram[0:65535];
  int          bsy = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_a = '0;
  int          n_mwr = 0, n_mrd = 0, mem_viol = 0, mw_cyc = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] last_wd = '0;
  assign mem_busy = (bsy != 0);

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if ((mem_wr || mem_rd) && (mem_busy || (mem_wr && mem_rd) || !mem_req))
      mem_viol <= mem_viol + 1;
    if (mem_wr) begin
      sram[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      last_wd <= mem_wdata;
      n_mwr <= n_mwr + 1;
      mw_cyc <= cyc;
      bsy <= 5;
    end
    if (mem_rd) begin
      rd_pend <= 1'b1;
      rd_a <= mem_addr;
      n_mrd <= n_mrd + 1;
      bsy <= 5;
    end
    if (!(mem_wr || mem_rd) && bsy != 0) begin
      bsy <= bsy - 1;
      if (bsy == 1 && rd_pend) begin
        mem_rvalid <= 1'b1;
        mem_rdata <= sram[rd_a];
        rd_pend <= 1'b0;
      end
    end
  end

  // log BRAM model, read data 3 cycles after the strobe
  logic [23:0] lmem[0:1023];
  int          lcnt = 0, n_lwr = 0, n_lrd = 0, lrv_cyc = 0;
  logic [9:0]  la = '0, lwr_addr = '0;
  logic [23:0] lwr_data = '0;
  int          n_gdp = 0, gdp_cyc = 0;

  always @(posedge clk) begin
    log_rvalid <= 1'b0;
    if (gdp_trigger_init) begin
      n_gdp <= n_gdp + 1;
      gdp_cyc <= cyc;
    end
    if (log_wr) begin
      lmem[log_addr] <= log_wdata;
      lwr_addr <= log_addr;
      lwr_data <= log_wdata;
      n_lwr <= n_lwr + 1;
    end
    if (log_rd) begin
      la <= log_addr;
      lcnt <= 3;
      n_lrd <= n_lrd + 1;
    end else if (lcnt != 0) begin
      lcnt <= lcnt - 1;
      if (lcnt == 1) begin
        log_rvalid <= 1'b1;
        log_rdata <= lmem[la];
        lrv_cyc <= cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
    repeat (30) @(negedge clk);
  endtask

  task automatic clear_tx();
    txq.delete();
    txcyc.delete();
  endtask

  task automatic test_reset();
    logic [83:0] outs;
    for (int k = 0; k < 2; k++) begin
      outs = {tx_data, tx_req, mem_req, mem_wr, mem_rd, mem_addr, mem_wdata,
              log_addr, log_wdata, log_wr, log_rd, gdp_trigger_init};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", k, outs);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_ping();
    int s0;
    s0 = n_mwr + n_mrd + n_lwr + n_lrd;
    clear_tx();
    send_byte(8'h80);
    wait_tx(1, 50);
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL ping_resp: got %0d bytes first %h expected 1 byte 01",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
    end
    checks++;
    if (txq.size() > 0 && txcyc[0] - last_rx_cyc !== 2) begin
      errors++;
      $display("FAIL ping_latency: got %0d expected 2", txcyc[0] - last_rx_cyc);
    end
    checks++;
    if (n_mwr + n_mrd + n_lwr + n_lrd !== s0) begin
      errors++;
      $display("FAIL ping_strobes: got %0d expected %0d", n_mwr + n_mrd + n_lwr + n_lrd, s0);
    end
  endtask

  task automatic test_gdp();
    int g0;
    g0 = n_gdp;
    clear_tx();
    send_byte(8'h81);
    wait_tx(1, 50);
    checks++;
    if (n_gdp - g0 !== 1) begin
      errors++;
      $display("FAIL gdp_pulses: got %0d expected 1", n_gdp - g0);
    end
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'h01 || gdp_cyc >= txcyc[0]) begin
      errors++;
      $display("FAIL gdp_ack: got %0d bytes gdp_cyc %0d expected 01 after pulse",
               txq.size(), gdp_cyc);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] exp[$];
    int w0;
    w0 = n_mwr;
    clear_tx();
    exp = '{8'h02, 8'h12, 8'h34, 8'hBE, 8'hEF};
    foreach (exp[i]) send_byte(exp[i]);
    wait_tx(1, 50);
    checks++;
    if (n_mwr - w0 !== 1 || wr_addr_q[$] !== 16'h1234 || last_wd !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_strobe: got %0d writes addr %h data %h expected 1 at 1234 BEEF",
               n_mwr - w0, wr_addr_q[$], last_wd);
    end
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'h01 || txcyc[0] <= mw_cyc || mw_cyc <= last_rx_cyc) begin
      errors++;
      $display("FAIL write_ack: got %0d bytes, wr cyc %0d rx cyc %0d expected ack after strobe",
               txq.size(), mw_cyc, last_rx_cyc);
    end
    clear_tx();
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
    wait_tx(4, 100);
    exp = '{8'h02, 8'hBE, 8'hEF, 8'h01};
    checks++;
    if (txq.size() !== exp.size()) begin
      errors++;
      $display("FAIL read_len: got %0d expected %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== exp[i]) begin
        errors++;
        $display("FAIL read_byte[%0d]: got %h expected %h", i,
                 (i < txq.size()) ? txq[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_bulk();
    logic [7:0]  cmd[$];
    logic [7:0]  exp[$];
    logic [15:0] ea[3];
    int w0;
    w0 = n_mwr;
    clear_tx();
    cmd = '{8'h01, 8'hFF, 8'hFE, 8'h00, 8'h03,
            8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    foreach (cmd[i]) send_byte(cmd[i]);
    wait_tx(1, 100);
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000};
    checks++;
    if (n_mwr - w0 !== 3 || txq.size() !== 1 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL bulk_write: got %0d writes %0d bytes expected 3 writes, ack",
               n_mwr - w0, txq.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_q.size() < 3 || wr_addr_q[wr_addr_q.size() - 3 + i] !== ea[i]
          || sram[ea[i]] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL bulk_word[%0d]: got addr %h data %h expected %h %h", i,
                 wr_addr_q[wr_addr_q.size() - 3 + i], sram[ea[i]], ea[i], 16'(i + 1));
      end
    end
    clear_tx();
    cmd = '{8'h04, 8'hFF, 8'hFE, 8'h00, 8'h03};
    foreach (cmd[i]) send_byte(cmd[i]);
    wait_tx(8, 400);
    exp = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h01};
    checks++;
    if (txq.size() !== exp.size()) begin
      errors++;
      $display("FAIL bulk_read_len: got %0d expected %0d", txq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== exp[i]) begin
        errors++;
        $display("FAIL bulk_read_byte[%0d]: got %h expected %h", i,
                 (i < txq.size()) ? txq[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_bulk_zero();
    int s0;
    s0 = n_mwr + n_mrd;
    clear_tx();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h00);
    wait_tx(3, 100);
    checks++;
    if (txq.size() !== 3 || txq[0] !== 8'h02 || txq[1] !== 8'h01 || txq[2] !== 8'h01) begin
      errors++;
      $display("FAIL bulk_zero_resp: got %0d bytes expected 02 01 01", txq.size());
    end
    checks++;
    if (n_mwr + n_mrd !== s0) begin
      errors++;
      $display("FAIL bulk_zero_access: got %0d expected %0d", n_mwr + n_mrd, s0);
    end
  endtask

  task automatic test_log();
    logic [7:0] cmd[$];
    logic [7:0] exp[$];
    clear_tx();
    cmd = '{8'h10, 8'h03, 8'hFF, 8'hAA, 8'hBB, 8'hCC};
    foreach (cmd[i]) send_byte(cmd[i]);
    wait_tx(1, 50);
    checks++;
    if (lwr_addr !== 10'h3FF || lwr_data !== 24'hAABBCC || txq.size() !== 1 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL log_write: got addr %h data %h bytes %0d expected 3FF AABBCC ack",
               lwr_addr, lwr_data, txq.size());
    end
    clear_tx();
    send_byte(8'h11); send_byte(8'h03); send_byte(8'hFF);
    wait_tx(5, 100);
    exp = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h01};
    checks++;
    if (txq.size() !== exp.size() || txcyc[0] <= lrv_cyc) begin
      errors++;
      $display("FAIL log_read_len: got %0d bytes first at %0d capture %0d expected %0d after",
               txq.size(), (txq.size() > 0) ? txcyc[0] : 0, lrv_cyc, exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== exp[i]) begin
        errors++;
        $display("FAIL log_read_byte[%0d]: got %h expected %h", i,
                 (i < txq.size()) ? txq[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_err();
    clear_tx();
    send_byte(8'h42);
    wait_tx(1, 50);
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'hFF || txcyc[0] - last_rx_cyc !== 2) begin
      errors++;
      $display("FAIL bad_opcode: got %0d bytes first %h expected FF after 2 cycles",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'h00);
    end
    clear_tx();
    send_byte(8'h80);
    wait_tx(1, 50);
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL after_err_ping: got %0d bytes expected 01", txq.size());
    end
  endtask

  task automatic test_timeout();
    int w0, lat;
    w0 = n_mwr;
    clear_tx();
    send_byte(8'h02);
    @(negedge clk);
    rx_data = 8'h12;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_tx(1, 200);
    lat = (txcyc.size() > 0) ? txcyc[0] - last_rx_cyc : -1;
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'hFF || lat < 99 || lat > 101) begin
      errors++;
      $display("FAIL timeout: got %0d bytes latency %0d expected FF within 99..101",
               txq.size(), lat);
    end
    checks++;
    if (n_mwr !== w0) begin
      errors++;
      $display("FAIL timeout_write: got %0d writes expected 0", n_mwr - w0);
    end
  endtask

  task automatic test_reset_mid();
    logic [83:0] outs;
    clear_tx();
    send_byte(8'h04); send_byte(8'hFF); send_byte(8'hFE);
    send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 200 && txq.size() < 2; i++) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_req: got %b expected 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {tx_data, tx_req, mem_req, mem_wr, mem_rd, mem_addr, mem_wdata,
            log_addr, log_wdata, log_wr, log_rd, gdp_trigger_init};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0", outs);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    clear_tx();
    send_byte(8'h80);
    wait_tx(1, 50);
    checks++;
    if (txq.size() !== 1 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL post_reset_ping: got %0d bytes expected 01", txq.size());
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (tx_viol !== 0) begin
      errors++;
      $display("FAIL tx_protocol: got %0d violations expected 0", tx_viol);
    end
    checks++;
    if (mem_viol !== 0) begin
      errors++;
      $display("FAIL mem_protocol: got %0d violations expected 0", mem_viol);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_ping();
    test_gdp();
    test_write_read();
    test_bulk();
    test_bulk_zero();
    test_log();
    test_err();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
